l2_ecc_err_monitor: RTL

- Sits directly downstream of the L2 memory wrapper and consumes its single-bit ECC error indication.
- Counts ECC error events in two ways: a lifetime total, and a count within a programmable sliding time window.
- Raises a level interrupt when the windowed count reaches a programmable threshold.
- Exposes control and status through a simple valid/ready register port, so the system bus or the safety island can monitor L2 integrity.

---
 rtl/l2_ecc_err_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/l2_ecc_err_monitor.sv
// L2 ECC error monitor: lifetime and sliding-window error counts, threshold alert, register port.
// Define L2_ECC_TIMESTAMP_EN to add a free-running cycle counter and the TSTAMP register at 0x14.
module l2_ecc_err_monitor #(
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned WinWidth  = 24,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ecc_error_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [4:0]           req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 irq_o
);

  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegThresh = 3'd1;
  localparam logic [2:0] RegWindow = 3'd2;
  localparam logic [2:0] RegCount  = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StMonitor, StAlert} state_e;

  state_e                state_q, state_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [CntWidth-1:0]   thresh_q, thresh_d;
  logic [WinWidth-1:0]   window_q, window_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  sat_q, sat_d;
  logic [CntWidth-1:0]   win_cnt_q, win_cnt_d;
  logic [WinWidth-1:0]   win_cyc_q, win_cyc_d;
  logic                  irq_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic [DataWidth-1:0]  rd_val;

  logic       accept, wr_en, active, ev, cnt_clr, alert_clr, wrap, hit;
  logic [2:0] reg_sel;
  logic       unused_bits;

  assign reg_sel   = req_addr_i[4:2];
  assign accept    = req_valid_i && req_ready_q;
  assign wr_en     = accept && req_write_i;
  assign active    = (state_q != StIdle) && ctrl_en_q;
  assign ev        = active && ecc_error_i;
  assign cnt_clr   = wr_en && (reg_sel == RegCount);
  assign alert_clr = wr_en && (reg_sel == RegStatus) && req_wdata_i[0] && (state_q == StAlert);
  assign wrap      = (window_q != '0) && (win_cyc_q == window_q - WinWidth'(1));
  assign unused_bits = ^{req_addr_i[1:0], req_wdata_i};

`ifdef L2_ECC_TIMESTAMP_EN
  localparam logic [2:0] RegTstamp = 3'd5;

  logic [31:0] ts_cnt_q, tstamp_q;
  logic        ts_armed_q;

  // Latch the cycle count of the first counted error since reset or the last COUNT clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q   <= '0;
      tstamp_q   <= '0;
      ts_armed_q <= 1'b1;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (cnt_clr) begin
        tstamp_q   <= ev ? ts_cnt_q : 32'd0;
        ts_armed_q <= !ev;
      end else if (ts_armed_q && ev) begin
        tstamp_q   <= ts_cnt_q;
        ts_armed_q <= 1'b0;
      end
    end
  end
`endif

  // Read mux, sampled on the accept cycle.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegCtrl:   rd_val = DataWidth'(ctrl_en_q);
      RegThresh: rd_val = DataWidth'(thresh_q);
      RegWindow: rd_val = DataWidth'(window_q);
      RegCount:  rd_val = DataWidth'(count_q);
      RegStatus: rd_val = DataWidth'({win_cnt_q, sat_q, state_q == StAlert});
`ifdef L2_ECC_TIMESTAMP_EN
      RegTstamp: rd_val = DataWidth'(tstamp_q);
`endif
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ctrl_en_d   = ctrl_en_q;
    thresh_d    = thresh_q;
    window_d    = window_q;
    count_d     = count_q;
    sat_d       = sat_q;
    win_cnt_d   = win_cnt_q;
    win_cyc_d   = win_cyc_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;

    if (wr_en && reg_sel == RegCtrl)   ctrl_en_d = req_wdata_i[0];
    if (wr_en && reg_sel == RegThresh) thresh_d  = req_wdata_i[CntWidth-1:0];
    if (wr_en && reg_sel == RegWindow) window_d  = req_wdata_i[WinWidth-1:0];

    // Lifetime count: a clear and a same-cycle event leave COUNT at 1.
    if (cnt_clr) begin
      count_d = CntWidth'(ev);
      sat_d   = 1'b0;
    end else if (ev && count_q != CntMax) begin
      count_d = count_q + CntWidth'(1);
    end
    if (count_d == CntMax) sat_d = 1'b1;

    // Sliding window: an event on the restart cycle belongs to the new window.
    if (!active) begin
      win_cnt_d = '0;
      win_cyc_d = '0;
    end else if (alert_clr || wrap) begin
      win_cnt_d = CntWidth'(ecc_error_i);
      win_cyc_d = '0;
    end else begin
      win_cyc_d = win_cyc_q + WinWidth'(1);
      if (ecc_error_i && win_cnt_q != CntMax) win_cnt_d = win_cnt_q + CntWidth'(1);
    end
    hit = (thresh_q != '0) && (win_cnt_d >= thresh_q);

    case (state_q)
      StIdle:    if (ctrl_en_q) state_d = StMonitor;
      StMonitor: begin
        if (!ctrl_en_q) state_d = StIdle;
        else if (hit)   state_d = StAlert;
      end
      StAlert: begin
        if (!ctrl_en_q)     state_d = StIdle;
        else if (alert_clr) state_d = StMonitor;
      end
      default:   state_d = StIdle;
    endcase

    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rdata_d     = req_write_i ? '0 : rd_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ctrl_en_q   <= 1'b0;
      thresh_q    <= '0;
      window_q    <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      win_cnt_q   <= '0;
      win_cyc_q   <= '0;
      irq_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_en_q   <= ctrl_en_d;
      thresh_q    <= thresh_d;
      window_q    <= window_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      win_cnt_q   <= win_cnt_d;
      win_cyc_q   <= win_cyc_d;
      irq_q       <= (state_q == StAlert);
      req_ready_q <= !rsp_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign irq_o       = irq_q;

endmodule
